lsu_align: RTL and testbench
============================

Name: lsu_align

Overview:
- Parametrised load/store alignment unit between the execute stage and a word-wide data memory port.
- Accepts one byte/half/word/double access per handshake and generates a word-aligned memory address, byte-lane strobes and shifted write data.
- Returns sign- or zero-extended load data.
- Optionally splits accesses that cross a word boundary into two memory beats.

Parameters:
XLEN, 32, datapath/word width in bits; legal values 32 or 64.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  access request.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
req_unsigned  in  1  zero-extend load result (LBU/LHU/LWU).
req_addr  in  ADDR_W  byte address.
req_wdata  in  XLEN  store data, right-justified.
mem_valid  out  1  memory beat request.
mem_ready  in  1  memory accepts the beat.
mem_we  out  1  beat is a write.
mem_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero).
mem_wstrb  out  XLEN/8  byte-lane write enables; all zero for reads.
mem_wdata  out  XLEN  lane-shifted store data.
mem_rvalid  in  1  beat completion (read data or write ack), one pulse per accepted beat.
mem_rdata  in  XLEN  read data.
resp_valid  out  1  result available.
resp_ready  in  1  consumer takes the result.
resp_rdata  out  XLEN  extended load data; 0 for stores.
resp_err  out  1  illegal size, or crossing access without split support.

Behaviour:
- Reset values: mem_valid 0, mem_we 0, mem_addr 0, mem_wstrb 0, mem_wdata 0, resp_valid 0, resp_rdata 0, resp_err 0, state IDLE (req_ready 1).
- All mem_* and resp_* outputs are registered. req_ready is decoded from state.
- Definitions: BYTES = XLEN/8; off = req_addr mod BYTES; n = 1<<req_size bytes; cross = (off + n > BYTES).
  - Misaligned accesses that stay inside one word are single-beat and legal.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: on req_valid, latch the request.
  - Illegal size, or cross without the split feature: go to RESP with resp_err=1; no mem_valid is ever driven.
  - Otherwise go to ISSUE0.
- ISSUE0/ISSUE1: mem_valid=1. All mem_* outputs are held stable until mem_ready, then move to WAIT0/WAIT1.
- WAIT0: on mem_rvalid, capture the low part. Go to ISSUE1 if cross, else RESP.
- WAIT1: on mem_rvalid, capture the high part and go to RESP.
- RESP: resp_valid=1, held with stable data until resp_ready, then IDLE. No new request is accepted in the same cycle.
- Minimum latency: accept at cycle 0, mem_valid at cycle 1; with mem_ready at cycle 1 and mem_rvalid at cycle 2, resp_valid rises at cycle 3.
- Store lanes:
  - mem_wdata = req_wdata << 8*off.
  - mem_wstrb = ((1<<n)-1) << off, truncated to BYTES.
  - Beat1 carries the remaining upper bytes starting at lane 0, at mem_addr + BYTES.
- Load extraction:
  - Combine {beat1, beat0} >> 8*off.
  - Mask to n bytes.
  - Sign-extend from bit 8n-1 unless req_unsigned.
  - Word loads with XLEN=64 extend to 64 bits.
- mem_rvalid outside WAIT0/WAIT1 is ignored.
- Address wrap: beat1 address wraps modulo 2^ADDR_W.
- Reset mid-operation returns to IDLE immediately; an outstanding memory response arriving after reset is ignored.

Optional Feature:
LSU_SPLIT_MISALIGNED_EN
- Defined: crossing accesses are executed as two beats (ISSUE1/WAIT1 present).
- Undefined: ISSUE1/WAIT1 are not generated; any crossing access completes in RESP with resp_err=1 and zero memory traffic.

Decomposition:
- Package lsu_pkg holds:
  - size encodings (SZ_B/SZ_H/SZ_W/SZ_D);
  - the state enum;
  - a function byte_mask(size, off).
- One sub-module, lsu_lane_extend: combinational extraction plus sign/zero extension of load data, parametrised by XLEN.

Test Plan:
1. LB then LBU at 0x103, mem_rdata 0x80FF1234 -> resp_rdata 0xFFFFFF80 then 0x00000080; mem_addr 0x100, wstrb 0.
2. SH at 0x102, wdata 0x0000ABCD -> mem_addr 0x100, wstrb 4'b1100, wdata 0xABCD0000, resp_rdata 0.
3. LW at 0x102 with split: beat0 at 0x100 returns 0x44332211, beat1 at 0x104 returns 0x88776655 -> resp_rdata 0x66554433.
   - Macro undefined: resp_err=1 and mem_valid never asserted.
4. Back-pressure:
   - mem_ready low 3 cycles -> mem_* unchanged, req_ready 0.
   - resp_ready low 2 cycles -> resp_valid and resp_rdata held.
5. Reset asserted in WAIT0, then a late mem_rvalid -> outputs at reset values, req_ready 1, no resp_valid.
6. XLEN=32, req_size=11 -> resp_err=1 three... rather, resp_valid with resp_err=1 in 1 cycle after accept, and no memory beat.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and byte-lane mask helper for the load/store alignment unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_RESP
  } state_e;

  // Lane mask spanning two words so the overflow into the next word is kept.
  function automatic logic [15:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    case (size)
      SZ_B:    m = 16'h0001;
      SZ_H:    m = 16'h0003;
      SZ_W:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_lane_extend.sv
// Load data extraction: shifts the two-beat window down by the byte offset,
// masks to the access size and sign- or zero-extends to XLEN.
module lsu_lane_extend
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic [2*XLEN-1:0] i_data,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [1:0]        i_size,
  input  logic              i_uns,
  output logic [XLEN-1:0]   o_data
);

  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_mask;
  logic            w_sign;

  assign w_sh   = XLEN'(i_data >> {i_off, 3'b000});
  // A full-width shift yields zero, so a native-width access gets an all-ones mask.
  assign w_mask = ~({XLEN{1'b1}} << (8 << i_size));

  always_comb begin
    w_sign = 1'b0;
    case (i_size)
      SZ_B:    w_sign = w_sh[7];
      SZ_H:    w_sign = w_sh[15];
      SZ_W:    w_sign = w_sh[31];
      default: w_sign = w_sh[XLEN-1];
    endcase
  end

  assign o_data = (w_sh & w_mask) | ((w_sign && !i_uns) ? ~w_mask : '0);

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit between execute and a word-wide memory port.
// Define LSU_SPLIT_MISALIGNED_EN to run word-crossing accesses as two beats.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
`ifdef LSU_SPLIT_MISALIGNED_EN
  localparam int WW = 2 * XLEN;
`else
  localparam int WW = XLEN;
`endif
  localparam int SW = WW / 8;

  state_e r_state, w_state_nxt;

  logic [OFF_W-1:0]  w_off;
  logic              w_cross, w_illegal, w_err;
  logic [ADDR_W-1:0] w_addr_al;
  logic [WW-1:0]     w_wd_sh;
  logic [SW-1:0]     w_ws_sh;
  logic [2*XLEN-1:0] w_ext_in;
  logic [XLEN-1:0]   w_ext;

  logic              r_we, r_uns;
  logic [1:0]        r_size;
  logic [OFF_W-1:0]  r_off;
`ifdef LSU_SPLIT_MISALIGNED_EN
  logic              r_cross;
  logic [ADDR_W-1:0] r_addr1;
  logic [XLEN-1:0]   r_wd_hi;
  logic [BYTES-1:0]  r_ws_hi;
  logic [XLEN-1:0]   r_beat0;
`endif

  assign w_off     = req_addr[OFF_W-1:0];
  assign w_addr_al = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_cross   = (32'(w_off) + (32'd1 << req_size)) > 32'(BYTES);
  assign w_illegal = (XLEN == 32) && (req_size == SZ_D);
  assign w_wd_sh   = WW'({{XLEN{1'b0}}, req_wdata} << {w_off, 3'b000});
  assign w_ws_sh   = SW'(byte_mask(req_size, 3'(w_off)));
`ifdef LSU_SPLIT_MISALIGNED_EN
  assign w_err     = w_illegal;
  assign w_ext_in  = (r_state == ST_WAIT1) ? {mem_rdata, r_beat0} : {{XLEN{1'b0}}, mem_rdata};
`else
  assign w_err     = w_illegal | w_cross;
  assign w_ext_in  = {{XLEN{1'b0}}, mem_rdata};
`endif

  assign req_ready = (r_state == ST_IDLE);

  lsu_lane_extend #(.XLEN(XLEN), .OFF_W(OFF_W)) u_ext (
    .i_data (w_ext_in),
    .i_off  (r_off),
    .i_size (r_size),
    .i_uns  (r_uns),
    .o_data (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_state_nxt = w_err ? ST_RESP : ST_ISSUE0;
      ST_ISSUE0: if (mem_ready) w_state_nxt = ST_WAIT0;
`ifdef LSU_SPLIT_MISALIGNED_EN
      ST_WAIT0:  if (mem_rvalid) w_state_nxt = r_cross ? ST_ISSUE1 : ST_RESP;
      ST_ISSUE1: if (mem_ready) w_state_nxt = ST_WAIT1;
      ST_WAIT1:  if (mem_rvalid) w_state_nxt = ST_RESP;
`else
      ST_WAIT0:  if (mem_rvalid) w_state_nxt = ST_RESP;
`endif
      ST_RESP:   if (resp_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= SZ_B;
      r_off      <= '0;
`ifdef LSU_SPLIT_MISALIGNED_EN
      r_cross    <= 1'b0;
      r_addr1    <= '0;
      r_wd_hi    <= '0;
      r_ws_hi    <= '0;
      r_beat0    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_we   <= req_we;
          r_uns  <= req_unsigned;
          r_size <= req_size;
          r_off  <= w_off;
`ifdef LSU_SPLIT_MISALIGNED_EN
          r_cross <= w_cross;
          r_addr1 <= w_addr_al + ADDR_W'(BYTES);
          r_wd_hi <= req_we ? w_wd_sh[WW-1:XLEN] : '0;
          r_ws_hi <= req_we ? w_ws_sh[SW-1:BYTES] : '0;
`endif
          if (w_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            mem_valid <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= w_addr_al;
            mem_wstrb <= req_we ? w_ws_sh[BYTES-1:0] : '0;
            mem_wdata <= req_we ? w_wd_sh[XLEN-1:0] : '0;
          end
        end
        ST_ISSUE0, ST_ISSUE1: if (mem_ready) mem_valid <= 1'b0;
        ST_WAIT0: if (mem_rvalid) begin
`ifdef LSU_SPLIT_MISALIGNED_EN
          if (r_cross) begin
            r_beat0   <= mem_rdata;
            mem_valid <= 1'b1;
            mem_addr  <= r_addr1;
            mem_wstrb <= r_ws_hi;
            mem_wdata <= r_wd_hi;
          end else
`endif
          begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= r_we ? '0 : w_ext;
          end
        end
        ST_WAIT1: if (mem_rvalid) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= r_we ? '0 : w_ext;
        end
        ST_RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align (XLEN=32) with hand-computed expectations.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int ncmp = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  lsu_align #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; afterwards the DUT has accepted it.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Check the beat that must already be on the port, accept it, then complete it.
  task automatic beat(input string tag, input logic we, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] wd, input logic [31:0] rd);
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'd1);
    chk({tag, ".mem_we"},    64'(mem_we), 64'(we));
    chk({tag, ".mem_addr"},  64'(mem_addr), 64'(a));
    chk({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'(s));
    if (we) chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(wd));
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk({tag, ".mem_valid_drop"}, 64'(mem_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  // Response must already be valid; take it and confirm return to IDLE.
  task automatic resp(input string tag, input logic [31:0] rd, input logic err);
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, ".resp_rdata"}, 64'(resp_rdata), 64'(rd));
    chk({tag, ".resp_err"},   64'(resp_err), 64'(err));
    chk({tag, ".req_ready_in_resp"}, 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, ".resp_valid_drop"}, 64'(resp_valid), 64'd0);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; resp_ready = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst.mem_valid",  64'(mem_valid), 64'd0);
    chk("rst.mem_we",     64'(mem_we), 64'd0);
    chk("rst.mem_addr",   64'(mem_addr), 64'd0);
    chk("rst.mem_wstrb",  64'(mem_wstrb), 64'd0);
    chk("rst.mem_wdata",  64'(mem_wdata), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst.resp_err",   64'(resp_err), 64'd0);
    chk("rst.req_ready",  64'(req_ready), 64'd1);

    // LB / LBU at 0x103: top byte 0x80, minimum latency path.
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    chk("lb.req_ready", 64'(req_ready), 64'd0);
    beat("lb", 1'b0, 32'h100, 4'b0000, 32'h0, 32'h80FF1234);
    resp("lb", 32'hFFFFFF80, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    beat("lbu", 1'b0, 32'h100, 4'b0000, 32'h0, 32'h80FF1234);
    resp("lbu", 32'h00000080, 1'b0);

    // SH at 0x102: upper half lanes.
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD);
    beat("sh", 1'b1, 32'h100, 4'b1100, 32'hABCD0000, 32'h0);
    resp("sh", 32'h0, 1'b0);

    // SW aligned at 0x200.
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);
    beat("sw", 1'b1, 32'h200, 4'b1111, 32'hDEADBEEF, 32'h0);
    resp("sw", 32'h0, 1'b0);

    // LHU at 0x102 (misaligned but inside the word).
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    beat("lhu", 1'b0, 32'h100, 4'b0000, 32'h0, 32'h80010000);
    resp("lhu", 32'h00008001, 1'b0);

    // LW at 0x102 crosses the word boundary.
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
`ifdef LSU_SPLIT_MISALIGNED_EN
    beat("lw_x0", 1'b0, 32'h100, 4'b0000, 32'h0, 32'h44332211);
    beat("lw_x1", 1'b0, 32'h104, 4'b0000, 32'h0, 32'h88776655);
    resp("lw_x", 32'h66554433, 1'b0);
`else
    chk("lw_x.no_mem", 64'(mem_valid), 64'd0);
    resp("lw_x", 32'h0, 1'b1);
    chk("lw_x.no_mem_after", 64'(mem_valid), 64'd0);
`endif

    // Memory back-pressure on SB 0x101: beat must hold for 3 cycles.
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A);
    for (int i = 0; i < 3; i++) begin
      chk("bp.mem_valid", 64'(mem_valid), 64'd1);
      chk("bp.mem_addr",  64'(mem_addr), 64'h100);
      chk("bp.mem_wstrb", 64'(mem_wstrb), 64'b0010);
      chk("bp.mem_wdata", 64'(mem_wdata), 64'h00005A00);
      chk("bp.req_ready", 64'(req_ready), 64'd0);
      step();
    end
    beat("bp", 1'b1, 32'h100, 4'b0010, 32'h00005A00, 32'h0);
    resp("bp", 32'h0, 1'b0);

    // Response back-pressure on LH 0x100.
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
    beat("rbp", 1'b0, 32'h100, 4'b0000, 32'h0, 32'h12348001);
    for (int i = 0; i < 2; i++) begin
      chk("rbp.resp_valid", 64'(resp_valid), 64'd1);
      chk("rbp.resp_rdata", 64'(resp_rdata), 64'hFFFF8001);
      step();
    end
    resp("rbp", 32'hFFFF8001, 1'b0);

    // Illegal double access on a 32-bit datapath.
    issue(1'b0, 2'b11, 1'b0, 32'h400, 32'h0);
    chk("ill.no_mem", 64'(mem_valid), 64'd0);
    resp("ill", 32'h0, 1'b1);

    // Reset while waiting for the read, then a stale completion.
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mrst.mem_valid", 64'(mem_valid), 64'd0);
    chk("mrst.mem_addr",  64'(mem_addr), 64'd0);
    chk("mrst.req_ready", 64'(req_ready), 64'd1);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("mrst.resp_valid", 64'(resp_valid), 64'd0);
    chk("mrst.resp_rdata", 64'(resp_rdata), 64'd0);
    chk("mrst.mem_valid2", 64'(mem_valid), 64'd0);
    chk("mrst.req_ready2", 64'(req_ready), 64'd1);

    // Unit still works after the reset.
    issue(1'b0, 2'b00, 1'b1, 32'h001, 32'h0);
    beat("post", 1'b0, 32'h000, 4'b0000, 32'h0, 32'h0000C300);
    resp("post", 32'h000000C3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
